// File: rtl/rr_arbiter_pe_if.sv
// Handshake bundle between an arbitration cell, its requesters and its parent level.
// The cell side uses the slave modport; the requester/parent side uses master.
interface rr_arbiter_pe_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
);
    logic             Grant_IN;
    logic [N-1:0]     Request_IN;
    logic             Request_OUT;
    logic [N-1:0]     Grant_OUT;
    logic             Grant_Valid;
    logic [IDX_W-1:0] Grant_Index;

    modport master (
        output Grant_IN,
        output Request_IN,
        input  Request_OUT,
        input  Grant_OUT,
        input  Grant_Valid,
        input  Grant_Index
    );

    modport slave (
        input  Grant_IN,
        input  Request_IN,
        output Request_OUT,
        output Grant_OUT,
        output Grant_Valid,
        output Grant_Index
    );
endinterface

// File: rtl/rr_arbiter_pe.sv
// Registered N-way arbiter cell (round-robin or fixed priority) with grant hold limit,
// cascadable through Request_OUT / Grant_IN like the legacy priority-encoder cell.
module rr_arbiter_pe #(
    parameter int unsigned N        = 4,
    parameter int unsigned RR_MODE  = 1,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_pe_if.slave bus
);
    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N-1:0]       others_c;
    logic [IDX_W-1:0]   base_c;
    logic [IDX_W-1:0]   win_c;
    logic               take_c;
    logic               idle_c;
    logic               hold_hit_c;
    logic               hold_room_c;

    // First set bit of mask scanning circularly upward from ptr.
    function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] mask, input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] j;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IDX_W'((32'(ptr) + k) % N);
            if (!found && mask[j]) begin
                r     = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign bus.Request_OUT = |bus.Request_IN;
    assign bus.Grant_OUT   = grant_q;
    assign bus.Grant_Valid = valid_q;
    assign bus.Grant_Index = idx_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        take_c      = 1'b0;
        idle_c      = 1'b0;
        win_c       = '0;
        base_c      = (RR_MODE != 0) ? ptr_q : '0;
        // grant_q is one-hot on the owner, so it doubles as the owner mask
        others_c    = bus.Request_IN & ~grant_q;
        hold_hit_c  = (MAX_HOLD != 0) && ((32'(cnt_q) + 32'd1) > MAX_HOLD);
        hold_room_c = (MAX_HOLD != 0) && ((32'(cnt_q) + 32'd1) <= MAX_HOLD);

        case (state_q)
            IDLE: begin
                if (bus.Grant_IN && (|bus.Request_IN)) begin
                    take_c = 1'b1;
                    win_c  = sel(bus.Request_IN, base_c);
                end
            end
            OWNED: begin
                if (!bus.Grant_IN) begin
                    idle_c = 1'b1;
                end else if (!bus.Request_IN[idx_q]) begin
                    if (|bus.Request_IN) begin
                        take_c = 1'b1;
                        win_c  = sel(bus.Request_IN, base_c);
                    end else begin
                        idle_c = 1'b1;
                    end
                end else if (hold_hit_c && (|others_c)) begin
                    take_c = 1'b1;
                    win_c  = sel(others_c, base_c);
                end else if (hold_room_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: idle_c = 1'b1;
        endcase

        if (take_c) begin
            state_d = OWNED;
            grant_d = N'(1) << win_c;
            valid_d = 1'b1;
            idx_d   = win_c;
            cnt_d   = CNT_W'(1);
            if (RR_MODE != 0) begin
                ptr_d = IDX_W'((32'(win_c) + 32'd1) % N);
            end
        end else if (idle_c) begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/rr_arbiter_pe.md
Name: rr_arbiter_pe

Overview:
- Parametrised, registered successor to the team's 4-input fixed-priority encoder cell for the arbitration tree.
- Arbitrates N requesters under a parent enable (Grant_IN).
- Selectable mode: round-robin or fixed-priority.
- Holds the grant while the winner keeps requesting, up to a configurable limit.
- Cascades like the existing cell: Request_OUT feeds the parent level and Grant_IN comes from it, so trees of mixed cells still compose.

Parameters:
- N, 4, number of requesters (2..32).
- RR_MODE, 1, 1 = round-robin pointer; 0 = fixed priority, bit 0 highest.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while others wait; 0 = unlimited.
- IDX_W, clog2(N) (min 1), width of Grant_Index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Grant_IN  input  1  enable from the parent level; this cell may hold a grant only while it is high.
- Request_IN  input  N  per-requester request, level, held until served.
- Request_OUT  output  1  combinational OR of Request_IN, to the parent.
- Grant_OUT  output  N  registered one-hot grant (all-zero when idle).
- Grant_Valid  output  1  registered; high when Grant_OUT is non-zero.
- Grant_Index  output  IDX_W  registered binary index of the owner; 0 when idle.

Behaviour:
- Reset (async, any time, including mid-grant):
  - Grant_OUT=0, Grant_Valid=0, Grant_Index=0.
  - Pointer ptr=0, hold counter cnt=0, state IDLE.
  - Request_OUT stays combinational during reset.
- Request_OUT: |Request_IN, zero latency, independent of Grant_IN and state.
- Selection function sel(mask, ptr):
  - Returns the first set bit of mask scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - When RR_MODE=0, ptr is forced to 0 (pure priority, bit 0 wins, matching the legacy cell).
- State machine, evaluated at each clk edge:
  - IDLE:
    - If Grant_IN=1 and Request_IN!=0: owner=sel(Request_IN, ptr); go to OWNED next cycle with cnt=1.
    - Otherwise stay IDLE.
  - OWNED, checks in priority order:
    - (a) Grant_IN=0: clear grant, go to IDLE, ptr unchanged.
    - (b) Request_IN[owner]=0: rearbitrate in the same edge. If any request is set, the new owner is sel(Request_IN, ptr) (zero-bubble handoff) and cnt=1. If no request is set, go to IDLE.
    - (c) MAX_HOLD!=0, cnt>=MAX_HOLD, and other requests exist (Request_IN with the owner bit masked is non-zero): forced handoff. New owner is sel(Request_IN with the owner bit masked, ptr), cnt=1.
    - (d) Otherwise keep the owner; cnt increments, saturating at MAX_HOLD (unlimited mode: counter not used).
- Pointer update: whenever a new owner i is latched and RR_MODE=1, ptr <= (i+1) mod N. Wrap from N-1 to 0 is required.
- Grant latency: one cycle from request and Grant_IN both high to Grant_OUT high. Grant deassertion also takes one cycle.
- Invariants:
  - Grant_OUT is always one-hot or zero, never multi-hot.
  - Grant_Index always equals the encoded Grant_OUT.
- Grant_IN dropping and the owner's request dropping in the same cycle: rule (a) wins and the cell goes to IDLE.
- Requests arriving while Grant_IN=0 are ignored for granting but still raise Request_OUT.
- N=1 degenerates to a registered pass-through gated by Grant_IN; ptr stays 0.

Test Plan:
- Reset mid-grant: N=4, owner=2 granted; assert rst asynchronously between edges -> Grant_OUT=0000, Grant_Valid=0, Grant_Index=0 immediately, with no clk edge needed; after release, ptr=0.
- Round-robin fairness: RR_MODE=1, MAX_HOLD=1, Request_IN=1111, Grant_IN=1 held -> grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive cycles; Grant_Index 0, 1, 2, 3, 0.
- Fixed priority: RR_MODE=0, Request_IN=1110, then bit 0 rises -> grant 0010 held while bit 1 is held. When bit 1 drops with 1101 present, next grant is 0001, not 0100.
- Hold limit: MAX_HOLD=3, req0 held and req2 set -> 0001 for exactly 3 cycles, then 0100. Same test with req2 clear -> 0001 held indefinitely.
- Parent gating: Grant_IN=0 with Request_IN=0100 -> Request_OUT=1, Grant_OUT=0000. Raise Grant_IN -> 0100 one cycle later. Drop Grant_IN -> 0000 one cycle later, and ptr is unchanged.
- Zero-bubble handoff: owner 1 drops request while 1001 is pending and ptr=2 -> next cycle grant is 1000 (index 3) with no idle cycle; ptr becomes 0.
